// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   XLEN / STRB_W     : datapath width and byte-strobe width
//   LS_* indices      : bit positions inside the one-hot load_store_info vector
//   mem_state_e       : access FSM states
//   ls_misaligned()   : natural-alignment check used when MEM_MISALIGN_CHECK_EN is defined
package mem_pkg;
    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;
    localparam int LS_W   = 11;

    localparam int LS_LB  = 0;
    localparam int LS_LBU = 1;
    localparam int LS_LH  = 2;
    localparam int LS_LHU = 3;
    localparam int LS_LW  = 4;
    localparam int LS_LWU = 5;
    localparam int LS_LD  = 6;
    localparam int LS_SB  = 7;
    localparam int LS_SH  = 8;
    localparam int LS_SW  = 9;
    localparam int LS_SD  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Halfwords need off[0]==0, words off[1:0]==0, doublewords off==0.
    function automatic logic ls_misaligned(input logic [LS_W-1:0] info, input logic [2:0] off);
        return ((info[LS_LH] | info[LS_LHU] | info[LS_SH]) & off[0])
             | ((info[LS_LW] | info[LS_LWU] | info[LS_SW]) & (|off[1:0]))
             | ((info[LS_LD] | info[LS_SD]) & (|off));
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: 64-bit valid/ready data bus between the memory stage and memory.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_addr            : doubleword-aligned address
//   req_wen             : 1 = store
//   req_wdata/req_wstrb : lane-aligned store data and byte strobes
//   resp_valid          : one-cycle response (load data or store ack)
//   resp_rdata          : full doubleword load data
// master = memory stage, slave = memory side.
interface mem_stage_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_addr;
    logic              req_wen;
    logic [XLEN-1:0]   req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the memory stage.
//   ls_info_i  : one-hot load/store kind
//   off_i      : byte offset within the doubleword
//   st_data_i  : store source data (right-aligned)
//   ld_raw_i   : raw doubleword returned by the bus
//   wdata_o    : store data shifted into its byte lanes (0 for non-stores)
//   wstrb_o    : byte strobes (0 for non-stores)
//   ld_data_o  : extracted and sign/zero-extended load data
// Lanes shifted past byte 7 are simply dropped.
module mem_align
    import mem_pkg::*;
(
    input  logic [LS_W-1:0]   ls_info_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN-1:0]   ld_raw_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   ld_data_o
);
    logic [5:0]        shamt;
    logic              is_store;
    logic [STRB_W-1:0] base_strb;
    logic [XLEN-1:0]   x;

    assign shamt    = {off_i, 3'b000};
    assign is_store = |ls_info_i[LS_SD:LS_SB];

    always_comb begin
        base_strb = 8'hFF;
        if (ls_info_i[LS_SB])      base_strb = 8'h01;
        else if (ls_info_i[LS_SH]) base_strb = 8'h03;
        else if (ls_info_i[LS_SW]) base_strb = 8'h0F;

        wstrb_o = is_store ? (base_strb << off_i) : '0;
        wdata_o = is_store ? (st_data_i << shamt) : '0;
    end

    assign x = ld_raw_i >> shamt;

    always_comb begin
        ld_data_o = x;
        if (ls_info_i[LS_LB])       ld_data_o = {{56{x[7]}},  x[7:0]};
        else if (ls_info_i[LS_LBU]) ld_data_o = {56'd0,       x[7:0]};
        else if (ls_info_i[LS_LH])  ld_data_o = {{48{x[15]}}, x[15:0]};
        else if (ls_info_i[LS_LHU]) ld_data_o = {48'd0,       x[15:0]};
        else if (ls_info_i[LS_LW])  ld_data_o = {{32{x[31]}}, x[31:0]};
        else if (ls_info_i[LS_LWU]) ld_data_o = {32'd0,       x[31:0]};
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between regM and regW.
// Loads/stores go out over the dbus (mem_stage_if.master); the stage stalls
// (regM held, regW bubbled) until the access completes, then releases the
// instruction for exactly one cycle. Non-memory instructions pass through
// combinationally with zero latency.
//   clk, rst          : clock, asynchronous active-high reset
//   regM_i_*          : instruction fields from regM
//   dbus              : data bus master port
//   mem_o_stall       : hold regM / bubble regW
//   mem_o_*           : fields towards regW and commit trace
//   mem_o_misalign    : present only when MEM_MISALIGN_CHECK_EN is defined;
//                       misaligned accesses are then not issued and retire
//                       without a register write.
module mem_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LS_W-1:0]   regM_i_load_store_info,
    input  logic [XLEN-1:0]   regM_i_regdata2,
    input  logic [XLEN-1:0]   regM_i_alu_result,
    input  logic [4:0]        regM_i_rd,
    input  logic              regM_i_reg_wen,
    input  logic              regM_i_commit,
    input  logic [XLEN-1:0]   regM_i_commit_pre_pc,
    input  logic [31:0]       regM_i_commit_instr,
    input  logic [XLEN-1:0]   regM_i_commit_pc,
    mem_stage_if.master       dbus,
    output logic              mem_o_stall,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              mem_o_misalign,
`endif
    output logic [4:0]        mem_o_rd,
    output logic              mem_o_reg_wen,
    output logic [XLEN-1:0]   mem_o_wb_data,
    output logic              mem_o_commit,
    output logic [XLEN-1:0]   mem_o_commit_pre_pc,
    output logic [31:0]       mem_o_commit_instr,
    output logic [XLEN-1:0]   mem_o_commit_pc
);
    mem_state_e      state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            is_mem, is_store, is_load;
    logic [2:0]      off;
    logic            misaligned;
    logic            misalign_w;
    logic            stall_w;
    logic [XLEN-1:0] ld_data;

    assign is_mem   = |regM_i_load_store_info;
    assign is_store = |regM_i_load_store_info[LS_SD:LS_SB];
    assign is_load  = is_mem & ~is_store;
    assign off      = regM_i_alu_result[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = ls_misaligned(regM_i_load_store_info, off);
`else
    assign misaligned = 1'b0;
`endif

    // Access FSM: one request, one response, then a single release cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        stall_w        = 1'b0;
        misalign_w     = 1'b0;
        dbus.req_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_mem && !misaligned) begin
                    stall_w = 1'b1;
                    state_d = ST_REQ;
                end else if (is_mem) begin
                    // Misaligned: retire immediately, never touch the bus.
                    misalign_w = 1'b1;
                end
            end
            ST_REQ: begin
                stall_w        = 1'b1;
                dbus.req_valid = 1'b1;
                if (dbus.req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                stall_w = 1'b1;
                if (dbus.resp_valid) begin
                    rdata_d = dbus.resp_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    mem_align u_align (
        .ls_info_i (regM_i_load_store_info),
        .off_i     (off),
        .st_data_i (regM_i_regdata2),
        .ld_raw_i  (rdata_q),
        .wdata_o   (dbus.req_wdata),
        .wstrb_o   (dbus.req_wstrb),
        .ld_data_o (ld_data)
    );

    // regM is held while stalled, so the request fields stay stable until accepted.
    assign dbus.req_addr = {regM_i_alu_result[XLEN-1:3], 3'b000};
    assign dbus.req_wen  = is_store;

    assign mem_o_stall         = stall_w;
    assign mem_o_rd            = regM_i_rd;
    assign mem_o_reg_wen       = regM_i_reg_wen & ~stall_w & ~misalign_w;
    assign mem_o_wb_data       = is_load ? ld_data : regM_i_alu_result;
    assign mem_o_commit        = regM_i_commit & ~stall_w;
    assign mem_o_commit_pre_pc = regM_i_commit_pre_pc;
    assign mem_o_commit_instr  = regM_i_commit_instr;
    assign mem_o_commit_pc     = regM_i_commit_pc;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mem_o_misalign = misalign_w;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Expected retirements are pushed
// to a scoreboard when an instruction is driven and popped when the DUT commits.
// Build with MEM_MISALIGN_CHECK_EN to include the misalignment step.
module tb_mem_stage;
    import mem_pkg::*;

    localparam logic [10:0] I_NONE = 11'h000;
    localparam logic [10:0] I_LB   = 11'h001;
    localparam logic [10:0] I_LBU  = 11'h002;
    localparam logic [10:0] I_LH   = 11'h004;
    localparam logic [10:0] I_LHU  = 11'h008;
    localparam logic [10:0] I_LW   = 11'h010;
    localparam logic [10:0] I_LWU  = 11'h020;
    localparam logic [10:0] I_LD   = 11'h040;
    localparam logic [10:0] I_SH   = 11'h100;
    localparam logic [10:0] I_SD   = 11'h400;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ls_info;
    logic [63:0] regdata2, alu_result, pre_pc, pc;
    logic [4:0]  rd;
    logic        reg_wen, commit;
    logic [31:0] instr;

    logic        stall_o, reg_wen_o, commit_o;
    logic [4:0]  rd_o;
    logic [63:0] wb_o, pre_pc_o, pc_o;
    logic [31:0] instr_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    mem_stage_if dbus();

    mem_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_i_load_store_info (ls_info),
        .regM_i_regdata2        (regdata2),
        .regM_i_alu_result      (alu_result),
        .regM_i_rd              (rd),
        .regM_i_reg_wen         (reg_wen),
        .regM_i_commit          (commit),
        .regM_i_commit_pre_pc   (pre_pc),
        .regM_i_commit_instr    (instr),
        .regM_i_commit_pc       (pc),
        .dbus                   (dbus),
        .mem_o_stall            (stall_o),
`ifdef MEM_MISALIGN_CHECK_EN
        .mem_o_misalign         (misalign_o),
`endif
        .mem_o_rd               (rd_o),
        .mem_o_reg_wen          (reg_wen_o),
        .mem_o_wb_data          (wb_o),
        .mem_o_commit           (commit_o),
        .mem_o_commit_pre_pc    (pre_pc_o),
        .mem_o_commit_instr     (instr_o),
        .mem_o_commit_pc        (pc_o)
    );

    typedef struct {
        logic        chk_wb;
        logic [63:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] addr;
        logic        req_wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample point: compare bus request against the head entry, retire on commit.
    task automatic at_neg();
        exp_t e;
        @(negedge clk);
        if (dbus.req_valid && sb.size() > 0) begin
            chk("req_addr",  dbus.req_addr,         sb[0].addr);
            chk("req_wen",   64'(dbus.req_wen),     64'(sb[0].req_wen));
            chk("req_wdata", dbus.req_wdata,        sb[0].wdata);
            chk("req_wstrb", 64'(dbus.req_wstrb),   64'(sb[0].wstrb));
        end
        if (commit_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 64'(commit_o), 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.chk_wb) chk("wb_data", wb_o, e.wb);
                chk("rd",      64'(rd_o),      64'(e.rd));
                chk("reg_wen", 64'(reg_wen_o), 64'(e.wen));
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] i, input logic [63:0] d2, input logic [63:0] a,
                         input logic [4:0] r, input logic w);
        ls_info    = i;
        regdata2   = d2;
        alu_result = a;
        rd         = r;
        reg_wen    = w;
        commit     = 1'b1;
        pc         = 64'h8000_0000 + a;
        pre_pc     = 64'h8000_0004 + a;
        instr      = 32'h0000_0013 ^ a[31:0];
    endtask

    task automatic bubble();
        ls_info = '0; regdata2 = '0; alu_result = '0; rd = '0;
        reg_wen = 1'b0; commit = 1'b0; pc = '0; pre_pc = '0; instr = '0;
    endtask

    task automatic push(input logic cw, input logic [63:0] wb, input logic [4:0] r, input logic w,
                        input logic [63:0] ad, input logic rw, input logic [63:0] wd, input logic [7:0] ws);
        exp_t e;
        e.chk_wb = cw; e.wb = wb; e.rd = r; e.wen = w;
        e.addr = ad; e.req_wen = rw; e.wdata = wd; e.wstrb = ws;
        sb.push_back(e);
    endtask

    // Run until the current instruction commits; replaces it with a bubble afterwards.
    task automatic run_commit(input string tag, input int max, output int stalls);
        logic done;
        done   = 1'b0;
        stalls = 0;
        for (int i = 0; i < max && !done; i++) begin
            at_neg();
            if (stall_o) stalls++;
            if (commit_o) begin
                done = 1'b1;
                bubble();
            end
            to_pos();
        end
        if (!done) chk({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    typedef struct {
        logic [10:0] info;
        logic [63:0] addr;
        logic [63:0] exp;
    } ld_vec_t;

    ld_vec_t lv[7];

    initial begin
        int st;
        lv[0] = '{I_LB,  64'h4000, 64'hFFFF_FFFF_FFFF_FFFF};
        lv[1] = '{I_LBU, 64'h4007, 64'h0000_0000_0000_0088};
        lv[2] = '{I_LH,  64'h4006, 64'hFFFF_FFFF_FFFF_8899};
        lv[3] = '{I_LHU, 64'h4002, 64'h0000_0000_0000_CCDD};
        lv[4] = '{I_LW,  64'h4004, 64'hFFFF_FFFF_8899_AABB};
        lv[5] = '{I_LWU, 64'h4000, 64'h0000_0000_CCDD_EEFF};
        lv[6] = '{I_LD,  64'h4000, 64'h8899_AABB_CCDD_EEFF};

        // Reset state
        rst = 1'b1;
        bubble();
        dbus.req_ready  = 1'b0;
        dbus.resp_valid = 1'b0;
        dbus.resp_rdata = '0;
        at_neg();
        chk("rst_stall",     64'(stall_o),          64'd0);
        chk("rst_req_valid", 64'(dbus.req_valid),   64'd0);
        chk("rst_wb",        wb_o,                  64'd0);
        chk("rst_commit",    64'(commit_o),         64'd0);
        chk("rst_wstrb",     64'(dbus.req_wstrb),   64'd0);
        chk("rst_addr",      dbus.req_addr,         64'd0);
        to_pos();
        rst = 1'b0;
        to_pos();

        // Non-memory instruction passes through in the same cycle
        drive(I_NONE, 64'h0, 64'h1234, 5'd5, 1'b1);
        push(1'b1, 64'h1234, 5'd5, 1'b1, 64'h0, 1'b0, 64'h0, 8'h0);
        at_neg();
        chk("add_stall",  64'(stall_o),        64'd0);
        chk("add_commit", 64'(commit_o),       64'd1);
        chk("add_pc",     pc_o,                64'h8000_1234);
        chk("add_pre_pc", pre_pc_o,            64'h8000_1238);
        chk("add_instr",  64'(instr_o),        64'h0000_1227);
        chk("add_reqv",   64'(dbus.req_valid), 64'd0);
        to_pos();
        bubble();

        // lb at offset 3, zero-wait bus: 3 stall cycles then release
        dbus.req_ready  = 1'b1;
        dbus.resp_valid = 1'b1;
        dbus.resp_rdata = 64'h0000_0000_8000_0000;
        drive(I_LB, 64'h0, 64'h1003, 5'd7, 1'b1);
        push(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 64'h1000, 1'b0, 64'h0, 8'h00);
        run_commit("lb", 10, st);
        chk("lb_stalls", 64'(st), 64'd3);

        // sh at offset 6
        drive(I_SH, 64'hBEEF, 64'h2006, 5'd0, 1'b0);
        push(1'b1, 64'h2006, 5'd0, 1'b0, 64'h2000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0);
        run_commit("sh", 10, st);
        chk("sh_stalls", 64'(st), 64'd3);

        // Load extraction across kinds and offsets
        dbus.resp_rdata = 64'h8899_AABB_CCDD_EEFF;
        foreach (lv[k]) begin
            drive(lv[k].info, 64'h0, lv[k].addr, 5'(k + 1), 1'b1);
            push(1'b1, lv[k].exp, 5'(k + 1), 1'b1, 64'h4000, 1'b0, 64'h0, 8'h00);
            run_commit("ld_tab", 10, st);
        end

        // Request back-pressure: ready low for 5 cycles in REQ
        dbus.req_ready  = 1'b0;
        dbus.resp_valid = 1'b0;
        drive(I_SD, 64'h0123_4567_89AB_CDEF, 64'h3000, 5'd0, 1'b0);
        push(1'b1, 64'h3000, 5'd0, 1'b0, 64'h3000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        at_neg();
        chk("bp_idle_stall", 64'(stall_o),        64'd1);
        chk("bp_idle_reqv",  64'(dbus.req_valid), 64'd0);
        to_pos();
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("bp_reqv",  64'(dbus.req_valid), 64'd1);
            chk("bp_stall", 64'(stall_o),        64'd1);
            to_pos();
        end
        dbus.req_ready  = 1'b1;
        dbus.resp_valid = 1'b1;
        run_commit("bp", 10, st);
        chk("bp_tail_stalls", 64'(st), 64'd2);

        // Reset while waiting for a response; the late response is ignored
        dbus.resp_valid = 1'b0;
        drive(I_LW, 64'h0, 64'h5000, 5'd9, 1'b1);
        at_neg();
        chk("rr_idle_stall", 64'(stall_o), 64'd1);
        to_pos();
        at_neg();
        chk("rr_req_valid", 64'(dbus.req_valid), 64'd1);
        to_pos();
        at_neg();
        chk("rr_resp_stall", 64'(stall_o),        64'd1);
        chk("rr_resp_reqv",  64'(dbus.req_valid), 64'd0);
        rst = 1'b1;
        bubble();
        #1;
        chk("rr_async_stall", 64'(stall_o), 64'd0);
        to_pos();
        at_neg();
        chk("rr_wb",     wb_o,                  64'd0);
        chk("rr_commit", 64'(commit_o),         64'd0);
        chk("rr_wen",    64'(reg_wen_o),        64'd0);
        chk("rr_reqv",   64'(dbus.req_valid),   64'd0);
        rst = 1'b0;
        dbus.resp_valid = 1'b1;
        dbus.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        to_pos();
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("rr_late_stall", 64'(stall_o),        64'd0);
            chk("rr_late_reqv",  64'(dbus.req_valid), 64'd0);
            to_pos();
        end
        dbus.resp_rdata = 64'h1122_3344_5566_7788;
        drive(I_LD, 64'h0, 64'h6000, 5'd3, 1'b1);
        push(1'b1, 64'h1122_3344_5566_7788, 5'd3, 1'b1, 64'h6000, 1'b0, 64'h0, 8'h00);
        run_commit("post_rst_ld", 10, st);
        chk("post_rst_stalls", 64'(st), 64'd3);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned word load retires at once without a bus request or write
        drive(I_LW, 64'h0, 64'h1002, 5'd4, 1'b1);
        push(1'b0, 64'h0, 5'd4, 1'b0, 64'h1000, 1'b0, 64'h0, 8'h00);
        at_neg();
        chk("mis_flag",   64'(misalign_o),       64'd1);
        chk("mis_reqv",   64'(dbus.req_valid),   64'd0);
        chk("mis_stall",  64'(stall_o),          64'd0);
        chk("mis_commit", 64'(commit_o),         64'd1);
        to_pos();
        bubble();
        at_neg();
        chk("mis_clear",  64'(misalign_o),       64'd0);
        to_pos();
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
